load_store_unit: RTL and testbench

//  Memory stage of the RISC-V core: takes the ALU-computed byte address plus store data, performs
//  RV32I loads/stores on on-chip data RAM, and drives ReadData into the writeback select mux.
//  RAM has registered (1-cycle) read, so loads are multi-cycle and stall the core; stores complete
//  in one cycle. Detects misaligned/illegal accesses and suppresses them.

---
 rtl/lsu_pkg.sv | 43 ++++
 rtl/data_ram.sv | 33 +++
 rtl/load_store_unit.sv | 147 ++++++++++++++
 tb/tb_load_store_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// ============================================================================
// Module : lsu_pkg
// Brief  : Shared types, funct3 encodings and access-legality helper for the
//          RV32I load/store unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // True when the access must be dropped: unknown width, unsigned store,
    // or an address that is not naturally aligned for its width.
    function automatic logic access_illegal(input logic [2:0] f3,
                                            input logic       is_store,
                                            input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (f3)
            F3_B, F3_BU: bad = 1'b0;
            F3_H, F3_HU: bad = addr_lo[0];
            F3_W:        bad = (addr_lo != 2'b00);
            default:     bad = 1'b1;
        endcase
        if (is_store && f3[2])
            bad = 1'b1;
        return bad;
    endfunction

endpackage

`default_nettype wire

// File: rtl/data_ram.sv
// ============================================================================
// Module : data_ram
// Brief  : Single-port data RAM, per-byte write enables, registered read.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module data_ram #(
    parameter int ADDR_BITS  = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic [DATA_WIDTH/8-1:0]   we,
    input  logic                      re,
    input  logic [ADDR_BITS-1:0]      addr,
    input  logic [DATA_WIDTH-1:0]     wdata,
    output logic [DATA_WIDTH-1:0]     rdata
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_BITS)-1];

    always_ff @(posedge clk) begin
        for (int i = 0; i < DATA_WIDTH/8; i++) begin
            if (we[i])
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
        if (re)
            rdata <= mem[addr];
    end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module : load_store_unit
// Brief  : RV32I memory stage: byte-lane stores, multi-cycle formatted loads,
//          misalignment / illegal-funct3 suppression.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_ADDR_BITS = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_en,
    input  logic                  MemWrite,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] ALU_result,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  rdata_valid,
    output logic                  stall,
    output logic                  access_fault
);

    state_t                  state;
    state_t                  state_next;
    logic                    load_go;
    logic                    store_go;
    logic                    fault_go;
    logic                    stall_fsm;
    logic [1:0]              addr_lo_q;
    logic [2:0]              funct3_q;
    logic [3:0]              byte_en;
    logic [DATA_WIDTH-1:0]   store_data;
    logic [DATA_WIDTH-1:0]   ram_rdata;
    logic [DATA_WIDTH-1:0]   load_fmt;
    logic [7:0]              byte_val;
    logic [15:0]             half_val;
    logic                    unused_addr_hi;

    // Address bits above the RAM index are deliberately ignored (wrap).
    assign unused_addr_hi = ^ALU_result[DATA_WIDTH-1:MEM_ADDR_BITS+2];

    always_comb begin
        state_next = state;
        load_go    = 1'b0;
        store_go   = 1'b0;
        fault_go   = 1'b0;
        stall_fsm  = 1'b0;
        case (state)
            IDLE: begin
                if (mem_en) begin
                    if (access_illegal(funct3, MemWrite, ALU_result[1:0])) begin
                        fault_go = 1'b1;
                    end else if (MemWrite) begin
                        store_go = 1'b1;
                    end else begin
                        load_go    = 1'b1;
                        stall_fsm  = 1'b1;
                        state_next = READ;
                    end
                end
            end
            READ: begin
                stall_fsm  = 1'b1;
                state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Reset releases the pipeline at once, even if the load is still presented.
    assign stall = stall_fsm & ~rst;

    always_comb begin
        byte_en    = 4'b0000;
        store_data = WriteData;
        case (funct3[1:0])
            2'b00: begin
                byte_en    = 4'b0001 << ALU_result[1:0];
                store_data = {4{WriteData[7:0]}};
            end
            2'b01: begin
                byte_en    = ALU_result[1] ? 4'b1100 : 4'b0011;
                store_data = {2{WriteData[15:0]}};
            end
            default: begin
                byte_en    = 4'b1111;
                store_data = WriteData;
            end
        endcase
        if (!store_go)
            byte_en = 4'b0000;
    end

    data_ram #(
        .ADDR_BITS  (MEM_ADDR_BITS),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (byte_en),
        .re    (load_go),
        .addr  (ALU_result[MEM_ADDR_BITS+1:2]),
        .wdata (store_data),
        .rdata (ram_rdata)
    );

    always_comb begin
        byte_val = 8'(ram_rdata >> {addr_lo_q, 3'b000});
        half_val = addr_lo_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        case (funct3_q)
            F3_B:    load_fmt = {{(DATA_WIDTH-8){byte_val[7]}}, byte_val};
            F3_BU:   load_fmt = {{(DATA_WIDTH-8){1'b0}}, byte_val};
            F3_H:    load_fmt = {{(DATA_WIDTH-16){half_val[15]}}, half_val};
            F3_HU:   load_fmt = {{(DATA_WIDTH-16){1'b0}}, half_val};
            default: load_fmt = ram_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ReadData     <= '0;
            rdata_valid  <= 1'b0;
            access_fault <= 1'b0;
            addr_lo_q    <= 2'b00;
            funct3_q     <= 3'b000;
        end else begin
            state        <= state_next;
            rdata_valid  <= (state == READ);
            access_fault <= fault_go;
            if (load_go) begin
                addr_lo_q <= ALU_result[1:0];
                funct3_q  <= funct3;
            end
            if (state == READ)
                ReadData <= load_fmt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module : tb_load_store_unit
// Brief  : Directed + random bench for load_store_unit against a byte-array
//          memory model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_en;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [31:0] ALU_result;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        rdata_valid;
    logic        stall;
    logic        access_fault;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem_model [0:4095];
    logic [31:0] exp_rd;

    always #5 clk = ~clk;

    load_store_unit #(.DATA_WIDTH(32), .MEM_ADDR_BITS(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_en       (mem_en),
        .MemWrite     (MemWrite),
        .funct3       (funct3),
        .ALU_result   (ALU_result),
        .WriteData    (WriteData),
        .ReadData     (ReadData),
        .rdata_valid  (rdata_valid),
        .stall        (stall),
        .access_fault (access_fault)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_fault(input bit st, input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b1;
        if (st && f3[2]) return 1'b1;
        if (f3[1:0] == 2'b10) return a[1:0] != 2'b00;
        if (f3[1:0] == 2'b01) return a[0];
        return 1'b0;
    endfunction

    function automatic logic [7:0] mbyte(input logic [31:0] a);
        logic [11:0] off;
        off = a[11:0];
        return mem_model[off];
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        b = mbyte(a);
        h = {mbyte(a + 1), mbyte(a)};
        case (f3)
            F3_B:    return {{24{b[7]}}, b};
            F3_BU:   return {24'h0, b};
            F3_H:    return {{16{h[15]}}, h};
            F3_HU:   return {16'h0, h};
            default: return {mbyte(a + 3), mbyte(a + 2), h};
        endcase
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int n;
        logic [11:0] off;
        n = 1 << f3[1:0];
        for (int i = 0; i < n; i++) begin
            off = 12'(a + i);
            mem_model[off] = d[8*i +: 8];
        end
    endtask

    // Called at a falling edge; presents one instruction and follows it to completion.
    task automatic access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d);
        bit f;
        f = is_fault(st, f3, a);
        mem_en = 1'b1; MemWrite = st; funct3 = f3; ALU_result = a; WriteData = d;
        #1 check("stall_issue", {31'b0, stall}, {31'b0, !st && !f});
        @(posedge clk); @(negedge clk);
        check("fault_pulse", {31'b0, access_fault}, {31'b0, f});
        if (f || st) begin
            check("valid_idle", {31'b0, rdata_valid}, 32'd0);
            check("rd_hold", ReadData, exp_rd);
            if (!f) model_store(f3, a, d);
        end else begin
            check("stall_read", {31'b0, stall}, 32'd1);
            check("valid_read", {31'b0, rdata_valid}, 32'd0);
            @(posedge clk); @(negedge clk);
            exp_rd = model_load(f3, a);
            check("stall_resp", {31'b0, stall}, 32'd0);
            check("valid_resp", {31'b0, rdata_valid}, 32'd1);
            check("load_data", ReadData, exp_rd);
            mem_en = 1'b0;
            @(posedge clk); @(negedge clk);
            check("valid_after", {31'b0, rdata_valid}, 32'd0);
            check("fault_after", {31'b0, access_fault}, 32'd0);
            check("rd_hold_after", ReadData, exp_rd);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        logic [2:0]  f3;
        bit          st;

        rst = 1'b1; mem_en = 1'b0; MemWrite = 1'b0; funct3 = 3'b000;
        ALU_result = 32'h0; WriteData = 32'h0; exp_rd = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_rd", ReadData, 32'h0);
        check("reset_valid", {31'b0, rdata_valid}, 32'd0);
        check("reset_stall", {31'b0, stall}, 32'd0);
        check("reset_fault", {31'b0, access_fault}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Give the model and RAM identical known contents in the test region.
        for (int w = 0; w < 64; w++)
            access(1'b1, F3_W, 32'(w * 4), $urandom);

        access(1'b1, F3_W, 32'h10, 32'hDEADBEEF);
        access(1'b0, F3_W, 32'h10, 32'h0);
        check("lw_deadbeef", ReadData, 32'hDEADBEEF);

        access(1'b1, F3_B, 32'h13, 32'h0000_0080);
        access(1'b0, F3_B, 32'h13, 32'h0);
        check("lb_sign", ReadData, 32'hFFFFFF80);
        access(1'b0, F3_BU, 32'h13, 32'h0);
        check("lbu_zero", ReadData, 32'h00000080);
        access(1'b0, F3_W, 32'h10, 32'h0);
        check("lw_after_sb", ReadData, 32'h80ADBEEF);

        access(1'b1, F3_H, 32'h22, 32'h0000_8001);
        access(1'b0, F3_H, 32'h22, 32'h0);
        check("lh_sign", ReadData, 32'hFFFF8001);
        access(1'b0, F3_HU, 32'h22, 32'h0);
        check("lhu_zero", ReadData, 32'h00008001);
        access(1'b0, F3_W, 32'h20, 32'h0);

        access(1'b0, F3_W, 32'h11, 32'h0);
        access(1'b1, F3_H, 32'h23, 32'hFFFF_FFFF);
        access(1'b0, 3'b011, 32'h10, 32'h0);
        access(1'b1, F3_BU, 32'h10, 32'h1234_5678);
        access(1'b0, F3_W, 32'h10, 32'h0);
        check("faults_no_write", ReadData, 32'h80ADBEEF);

        // Reset while the RAM read is outstanding.
        mem_en = 1'b1; MemWrite = 1'b0; funct3 = F3_W; ALU_result = 32'h20;
        @(posedge clk); @(negedge clk);
        check("mid_stall_read", {31'b0, stall}, 32'd1);
        rst = 1'b1;
        #1;
        exp_rd = 32'h0;
        check("mid_rst_stall", {31'b0, stall}, 32'd0);
        check("mid_rst_rd", ReadData, 32'h0);
        @(posedge clk); @(negedge clk);
        check("mid_rst_valid", {31'b0, rdata_valid}, 32'd0);
        mem_en = 1'b0; rst = 1'b0;
        @(posedge clk); @(negedge clk);
        check("post_rst_valid", {31'b0, rdata_valid}, 32'd0);
        check("post_rst_rd", ReadData, 32'h0);
        access(1'b0, F3_W, 32'h10, 32'h0);
        check("lw_after_rst", ReadData, 32'h80ADBEEF);

        access(1'b1, F3_W, 32'h1000, 32'h1234_5678);
        access(1'b0, F3_W, 32'h0, 32'h0);
        check("wrap_lw", ReadData, 32'h12345678);

        for (int n = 0; n < 300; n++) begin
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1)
                a[1:0] = 2'b00;
            access(st, f3, a, $urandom);
        end
        mem_en = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
